// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: {cout,sum} = a + b + cin, one nibble per clock through one 4-bit adder.
// Ports: clk/rst (sync, active-high); start,a,b,cin request; busy,done status; sum,cout registered result.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         r_state, w_next;
  logic [W-1:0]   r_a, r_b, r_sum;
  logic [IW-1:0]  r_idx;
  logic           r_carry, r_cout;
  logic           w_accept, w_last;
  logic [4:0]     w_nib;
  assign w_accept = start && r_state != RUN;
  assign w_last   = r_idx == IW'(NIBBLES - 1);
  // the single shared nibble adder; the carry only crosses nibbles via r_carry
  assign w_nib = {1'b0, 4'(r_a >> {r_idx, 2'b00})} + {1'b0, 4'(r_b >> {r_idx, 2'b00})} + {4'b0, r_carry};
  always_comb
    w_next = w_accept ? RUN : (r_state == RUN && w_last) ? DONE : (r_state == DONE) ? IDLE : r_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_idx   <= '0;
        r_sum   <= '0;
        r_cout  <= 1'b0;
      end else if (r_state == RUN) begin
        r_sum[{r_idx, 2'b00} +: 4] <= w_nib[3:0];
        if (w_last) r_cout <= w_nib[4];
        else begin
          r_carry <= w_nib[4];
          r_idx   <= r_idx + 1'b1;
        end
      end
    end
  end
  assign busy = r_state == RUN;
  assign done = r_state == DONE;
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks of nibble_serial_adder against a cycle model.
module tb_nibble_serial_adder;
  logic        clk = 1'b0, rst, start, cin, busy, done, cout;
  logic [15:0] a, b, sum;
  int          checks = 0, errors = 0;
  logic        chk_on = 1'b0;
  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  always #5 clk = ~clk;
  logic [16:0] m_res;
  logic [15:0] m_sum;
  logic        m_done, m_cout;
  int          m_left, m_k;
  // model: full result is known at accept; after k edges the low k nibbles of it are visible
  always @(posedge clk) begin
    if (rst) begin
      m_res <= '0; m_sum <= '0; m_done <= 1'b0; m_cout <= 1'b0; m_left <= 0; m_k <= 0;
    end else if (start && m_left == 0) begin
      m_res <= {1'b0, a} + {1'b0, b} + 17'(cin);
      m_sum <= '0; m_cout <= 1'b0; m_done <= 1'b0; m_left <= 4; m_k <= 0;
    end else if (m_left > 0) begin
      m_sum  <= m_res[15:0] & 16'((32'd1 << (4 * (m_k + 1))) - 1);
      m_k    <= m_k + 1;
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_cout <= m_res[16];
      end
    end else m_done <= 1'b0;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_on) begin
    chk("cyc_busy", 32'(busy), 32'(m_left > 0));
    chk("cyc_done", 32'(done), 32'(m_done));
    chk("cyc_sum", 32'(sum), 32'(m_sum));
    if (m_left == 0) chk("cyc_cout", 32'(cout), 32'(m_cout));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 20) begin
      nb += int'(busy);
      tick();
      n++;
    end
  endtask
  task automatic count_done(input int cyc, output int nd);
    nd = 0;
    repeat (cyc) begin
      tick();
      nd += int'(done);
    end
  endtask
  task automatic op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                    input logic [15:0] es, input logic ec, input string nm);
    int n, nb;
    a = ia; b = ib; cin = ic; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    chk({nm, "_lat"}, 32'(n), 32'd4);
    chk({nm, "_busycyc"}, 32'(nb), 32'd4);
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    chk({nm, "_model"}, 32'({m_cout, m_sum}), 32'({ec, es}));
  endtask
  initial begin
    int n, nb, nd;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] rs;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) tick();
    chk_on = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, "basic");
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple_b");
    op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ripple_cin");
    op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, "mixed");
    op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "top_carry");
    tick();
    a = 16'h1111; b = 16'h1111; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    chk("ign_lat", 32'(n), 32'd1);
    chk("ign_sum", 32'(sum), 32'h2222);
    chk("ign_cout", 32'(cout), 32'd0);
    count_done(8, nd);
    chk("ign_single_done", 32'(nd), 32'd0);
    a = 16'h0005; b = 16'h0003; cin = 1'b0; start = 1'b1;
    tick();
    wait_done(n, nb);
    chk("b2b_first_lat", 32'(n), 32'd4);
    chk("b2b_first_sum", 32'(sum), 32'h0008);
    a = 16'h00F0; b = 16'h0010;
    tick();
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    chk("b2b_accept_done", 32'(done), 32'd0);
    chk("b2b_accept_sum", 32'(sum), 32'd0);
    start = 1'b0;
    tick();
    wait_done(n, nb);
    chk("b2b_second_lat", 32'(n), 32'd3);
    chk("b2b_second_sum", 32'(sum), 32'h0100);
    chk("b2b_second_cout", 32'(cout), 32'd0);
    tick();
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    count_done(8, nd);
    chk("abort_no_done", 32'(nd), 32'd0);
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      op(ra, rb, rc, rs[15:0], rs[16], "rand");
      repeat ($urandom_range(0, 3)) tick();
    end
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
